// File: rtl/sad_pkg.sv
// Shared types and sizing helpers for the stereo SAD frame accumulator.
package sad_pkg;

    localparam int DEF_NPIX  = 8;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_BEATS = 4800;

    typedef struct packed {
        logic valid;
        logic last;
        logic sof;
    } stage_tag_t;

    // Worst case is every pixel at full scale for a whole frame.
    function automatic int sad_acc_w(input int npix, input int pix_w, input int beats);
        return pix_w + $clog2(npix * beats);
    endfunction

endpackage

// File: rtl/sad_absdiff_tree.sv
// Per-lane |L-R| and a combinational adder tree; the caller places the
// pipeline register between the two halves.
module sad_absdiff_tree
    import sad_pkg::*;
#(
    parameter  int NPIX  = DEF_NPIX,
    parameter  int PIX_W = DEF_PIX_W,
    localparam int SUM_W = PIX_W + $clog2(NPIX)
) (
    input  logic [NPIX*PIX_W-1:0]        left,
    input  logic [NPIX*PIX_W-1:0]        right,
    output logic [NPIX-1:0][PIX_W-1:0]   diff,
    input  logic [NPIX-1:0][PIX_W-1:0]   lanes,
    output logic [SUM_W-1:0]             sum
);

    localparam int LEVELS = $clog2(NPIX);

    for (genvar k = 0; k < NPIX; k++) begin : g_lane
        logic [PIX_W-1:0] l, r;
        assign l       = left[k*PIX_W +: PIX_W];
        assign r       = right[k*PIX_W +: PIX_W];
        assign diff[k] = (l >= r) ? l - r : r - l;
    end

    logic [NPIX-1:0][SUM_W-1:0] node;

    // Pairwise reduction in place: level n folds the first NPIX>>n nodes.
    always_comb begin
        for (int k = 0; k < NPIX; k++) node[k] = SUM_W'(lanes[k]);
        for (int lvl = 0; lvl < LEVELS; lvl++)
            for (int i = 0; i < (NPIX >> (lvl + 1)); i++)
                node[i] = node[2*i] + node[2*i+1];
        sum = node[0];
    end

endmodule

// File: rtl/sad_frame_accum.sv
// Back-pressured stereo SAD frame accumulator (S1 absdiff, S2 tree sum, ACC).
// Optional per-frame peak beat sum output enabled by `define SAD_PEAK_EN.
module sad_frame_accum
    import sad_pkg::*;
#(
    parameter  int NPIX            = DEF_NPIX,
    parameter  int PIX_W           = DEF_PIX_W,
    parameter  int BEATS_PER_FRAME = DEF_BEATS,
    localparam int ACC_W           = sad_acc_w(NPIX, PIX_W, BEATS_PER_FRAME),
    localparam int SUM_W           = PIX_W + $clog2(NPIX),
    localparam int CNT_W           = $clog2(BEATS_PER_FRAME)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPIX*PIX_W-1:0]   s_left,
    input  logic [NPIX*PIX_W-1:0]   s_right,
    input  logic                    s_sof,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [ACC_W-1:0]        m_sad,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    frame_err,
`ifdef SAD_PEAK_EN
    output logic [SUM_W-1:0]        m_peak,
`endif
    output logic [CNT_W-1:0]        beat_cnt
);

    stage_tag_t                 in_tag, st1_tag, st2_tag;
    logic [NPIX-1:0][PIX_W-1:0] diff, st1_diff;
    logic [SUM_W-1:0]           tree_sum, st2_sum;
    logic [ACC_W-1:0]           acc, acc_next;
    logic                       adv, fire, cnt_last;

    // Only a finished frame that cannot retire blocks the pipe; everything freezes.
    assign adv      = !(m_valid && !m_ready && st2_tag.valid && st2_tag.last);
    assign s_ready  = adv;
    assign fire     = s_valid && adv;
    assign cnt_last = !s_sof && (beat_cnt == CNT_W'(BEATS_PER_FRAME - 1));
    assign in_tag   = '{valid: s_valid, last: s_valid && cnt_last, sof: s_valid && s_sof};

    sad_absdiff_tree #(.NPIX(NPIX), .PIX_W(PIX_W)) u_tree (
        .left  (s_left),
        .right (s_right),
        .diff  (diff),
        .lanes (st1_diff),
        .sum   (tree_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= fire && s_sof && (beat_cnt != '0);
            if (fire) begin
                if (s_sof)         beat_cnt <= CNT_W'(1);
                else if (cnt_last) beat_cnt <= '0;
                else               beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st1_tag  <= '0;
            st2_tag  <= '0;
            st1_diff <= '0;
            st2_sum  <= '0;
        end else if (adv) begin
            st1_tag  <= in_tag;
            st1_diff <= diff;
            st2_tag  <= st1_tag;
            st2_sum  <= tree_sum;
        end
    end

    assign acc_next = (st2_tag.sof ? '0 : acc) + ACC_W'(st2_sum);

    // Handshake clear first so a completing frame can reload in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            m_sad   <= '0;
            m_valid <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_sad   <= '0;
            end
            if (st2_tag.valid && adv) begin
                if (st2_tag.last) begin
                    m_sad   <= acc_next;
                    m_valid <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

`ifdef SAD_PEAK_EN
    logic [SUM_W-1:0] peak, peak_base, peak_next;

    assign peak_base = st2_tag.sof ? '0 : peak;
    assign peak_next = (st2_sum > peak_base) ? st2_sum : peak_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            peak   <= '0;
            m_peak <= '0;
        end else begin
            if (m_valid && m_ready) m_peak <= '0;
            if (st2_tag.valid && adv) begin
                if (st2_tag.last) begin
                    m_peak <= peak_next;
                    peak   <= '0;
                end else begin
                    peak <= peak_next;
                end
            end
        end
    end
`endif

endmodule
